// File: rtl/range_hood_mode_ctrl_if.sv
// Button inputs and status outputs of the range hood mode controller.
// master drives the buttons, slave is the controller itself.
interface range_hood_mode_ctrl_if #(
    parameter int NUM_LEVELS = 3
);
    logic                  machine_state;
    logic                  menu_btn;
    logic [NUM_LEVELS-1:0] level_btn;
    logic                  clean_btn;
    logic [3:0]            mode_state;
    logic                  menu_btn_state;
    logic                  hurricane_mode_enabled;
    logic [15:0]           remain_s;
    logic [1:0]            disp_sel;
    logic [NUM_LEVELS+1:0] led;
    logic                  clean_remind;

    modport master (
        output machine_state, menu_btn, level_btn, clean_btn,
        input  mode_state, menu_btn_state, hurricane_mode_enabled, remain_s,
               disp_sel, led, clean_remind
    );

    modport slave (
        input  machine_state, menu_btn, level_btn, clean_btn,
        output mode_state, menu_btn_state, hurricane_mode_enabled, remain_s,
               disp_sel, led, clean_remind
    );
endinterface

// File: rtl/range_hood_mode_ctrl.sv
// Range hood mode controller: power, menu, fan levels, hurricane boost, delayed return and self-clean.
// Defining CLEAN_REMIND_EN adds the run-time accumulator behind clean_remind.
module range_hood_mode_ctrl #(
    parameter int NUM_LEVELS  = 3,
    parameter int CLK_HZ      = 100000000,
    parameter int HURRICANE_S = 60,
    parameter int RETURN_S    = 60,
    parameter int CLEAN_S     = 180,
    parameter int REMIND_S    = 36000
) (
    input  logic                   clk,
    input  logic                   rst,
    range_hood_mode_ctrl_if.slave  bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_STANDBY,
        S_MENU,
        S_RUN,
        S_HURRICANE,
        S_RETURN,
        S_CLEAN
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            level_q, level_d;
    logic [15:0]           remain_q, remain_d;
    logic                  hur_en_q, hur_en_d;
    logic                  ms_prev_q;
    logic [PW-1:0]         presc_q, presc_d;
    logic [3:0]            mode_q, mode_d;
    logic                  menu_st_q;
    logic [1:0]            disp_q, disp_d;
    logic [NUM_LEVELS+1:0] led_q, led_d;
    logic                  remind_q, remind_d;
    logic                  tick_s, last_s, lvl_any_s, lvl_top_s;
    logic [3:0]            lvl_num_s;

    assign tick_s    = (presc_q == PW'(CLK_HZ - 1));
    assign last_s    = tick_s && (remain_q <= 16'd1);
    assign lvl_any_s = |bus.level_btn;
    assign lvl_top_s = bus.level_btn[NUM_LEVELS-1];
    // The prescaler realigns to every state entry so a timed state always lasts whole seconds.
    assign presc_d   = ((state_d != state_q) || tick_s) ? '0 : presc_q + PW'(1);

    // Highest pressed level button wins
    always_comb begin
        lvl_num_s = 4'd0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            lvl_num_s = bus.level_btn[i] ? 4'(i + 1) : lvl_num_s;
        end
    end

    // Next state, fan level, countdown and hurricane availability
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        remain_d = remain_q;
        hur_en_d = hur_en_q;
        if (!bus.machine_state) begin
            state_d  = S_OFF;
            remain_d = 16'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (!ms_prev_q) begin
                        state_d  = S_STANDBY;
                        hur_en_d = 1'b1;
                    end else begin
                        state_d = S_OFF;
                    end
                end
                S_STANDBY: begin
                    if (bus.menu_btn) begin
                        state_d = S_MENU;
                    end else begin
                        state_d = S_STANDBY;
                    end
                end
                S_MENU: begin
                    // A refused hurricane request still consumes the press.
                    if (bus.menu_btn) begin
                        state_d = S_STANDBY;
                    end else if (lvl_top_s) begin
                        if (hur_en_q) begin
                            state_d  = S_HURRICANE;
                            hur_en_d = 1'b0;
                            remain_d = 16'(HURRICANE_S);
                        end else begin
                            state_d = S_MENU;
                        end
                    end else if (lvl_any_s) begin
                        state_d = S_RUN;
                        level_d = lvl_num_s;
                    end else if (bus.clean_btn) begin
                        state_d  = S_CLEAN;
                        remain_d = 16'(CLEAN_S);
                    end else begin
                        state_d = S_MENU;
                    end
                end
                S_RUN: begin
                    if (bus.menu_btn) begin
                        state_d = S_STANDBY;
                    end else if (lvl_any_s && !lvl_top_s) begin
                        level_d = lvl_num_s;
                    end else begin
                        level_d = level_q;
                    end
                end
                S_HURRICANE: begin
                    if (bus.menu_btn) begin
                        state_d  = S_RETURN;
                        remain_d = 16'(RETURN_S);
                    end else if (last_s) begin
                        state_d  = S_RUN;
                        level_d  = 4'(NUM_LEVELS - 1);
                        remain_d = 16'd0;
                    end else if (tick_s) begin
                        remain_d = remain_q - 16'd1;
                    end else begin
                        remain_d = remain_q;
                    end
                end
                S_RETURN, S_CLEAN: begin
                    if (last_s) begin
                        state_d  = S_STANDBY;
                        remain_d = 16'd0;
                    end else if (tick_s) begin
                        remain_d = remain_q - 16'd1;
                    end else begin
                        remain_d = remain_q;
                    end
                end
                default: begin
                    state_d  = S_OFF;
                    remain_d = 16'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the outputs register alongside it
    always_comb begin
        case (state_d)
            S_OFF:             begin mode_d = 4'd15;                disp_d = 2'd3; end
            S_STANDBY, S_MENU: begin mode_d = 4'd0;                 disp_d = 2'd0; end
            S_RUN:             begin mode_d = level_d;              disp_d = 2'd1; end
            S_HURRICANE:       begin mode_d = 4'(NUM_LEVELS);       disp_d = 2'd1; end
            S_RETURN:          begin mode_d = 4'(NUM_LEVELS - 1);   disp_d = 2'd1; end
            S_CLEAN:           begin mode_d = 4'(NUM_LEVELS + 1);   disp_d = 2'd2; end
            default:           begin mode_d = 4'd15;                disp_d = 2'd3; end
        endcase
        for (int i = 0; i < NUM_LEVELS + 2; i++) begin
            led_d[i] = (state_d != S_OFF) && (mode_d == 4'(i));
        end
    end

`ifdef CLEAN_REMIND_EN
    logic [31:0] acc_q, acc_d;

    // Run-time accumulator: counts fan seconds, survives power-off, cleared by a finished clean
    always_comb begin
        if ((state_q == S_CLEAN) && (state_d == S_STANDBY)) begin
            acc_d = 32'd0;
        end else if (tick_s && (acc_q != 32'hFFFF_FFFF) &&
                     ((state_q == S_RUN) || (state_q == S_HURRICANE) || (state_q == S_RETURN))) begin
            acc_d = acc_q + 32'd1;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 32'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign remind_d = (acc_d >= 32'(REMIND_S));
`else
    logic remind_cfg_unused_s;
    assign remind_cfg_unused_s = ^32'(REMIND_S);
    assign remind_d            = 1'b0;
`endif

    // State, timer and registered output bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            level_q   <= 4'd1;
            remain_q  <= 16'd0;
            hur_en_q  <= 1'b0;
            ms_prev_q <= 1'b0;
            presc_q   <= '0;
            mode_q    <= 4'd15;
            menu_st_q <= 1'b0;
            disp_q    <= 2'd3;
            led_q     <= '0;
            remind_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            remain_q  <= remain_d;
            hur_en_q  <= hur_en_d;
            ms_prev_q <= bus.machine_state;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            menu_st_q <= (state_d == S_MENU);
            disp_q    <= disp_d;
            led_q     <= led_d;
            remind_q  <= remind_d;
        end
    end

    assign bus.mode_state             = mode_q;
    assign bus.menu_btn_state         = menu_st_q;
    assign bus.hurricane_mode_enabled = hur_en_q;
    assign bus.remain_s               = remain_q;
    assign bus.disp_sel               = disp_q;
    assign bus.led                    = led_q;
    assign bus.clean_remind           = remind_q;
endmodule

// File: tb/tb_range_hood_mode_ctrl.sv
// Bench for range_hood_mode_ctrl: directed scenarios with literal expectations, then random
// button traffic checked every cycle against an age-in-state reference model.
module tb_range_hood_mode_ctrl;
    localparam int NL     = 3;
    localparam int CLK_HZ = 10;
    localparam int HUR_S  = 3;
    localparam int RET_S  = 2;
    localparam int CLN_S  = 4;
    localparam int REM_S  = 5;
`ifdef CLEAN_REMIND_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif
    localparam int M_OFF = 0, M_STBY = 1, M_MENU = 2, M_RUN = 3, M_HUR = 4, M_RET = 5, M_CLN = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    range_hood_mode_ctrl_if #(.NUM_LEVELS(NL)) bus_if ();

    range_hood_mode_ctrl #(
        .NUM_LEVELS(NL), .CLK_HZ(CLK_HZ), .HURRICANE_S(HUR_S),
        .RETURN_S(RET_S), .CLEAN_S(CLN_S), .REMIND_S(REM_S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state name, seconds loaded on entry, edges spent in the state
    int     m_st, m_level, m_load, m_age;
    bit     m_hur, m_prev_ms, m_valid = 1'b0;
    longint m_acc;

    task automatic model_reset();
        m_st = M_OFF; m_level = 1; m_load = 0; m_age = 0;
        m_hur = 1'b0; m_prev_ms = 1'b0; m_acc = 0;
    endtask

    task automatic model_step(input bit ms, input bit menu, input logic [NL-1:0] lvl, input bit cln);
        int nxt, top;
        bit tick, done;
        nxt  = m_st;
        tick = (m_age % CLK_HZ) == CLK_HZ - 1;
        done = (m_age + 1) >= m_load * CLK_HZ;
        top  = 0;
        for (int i = 0; i < NL; i++) if (lvl[i]) top = i + 1;
        if (tick && (m_st == M_RUN || m_st == M_HUR || m_st == M_RET) && m_acc < 64'hFFFF_FFFF)
            m_acc++;
        if (!ms) nxt = M_OFF;
        else begin
            case (m_st)
                M_OFF:  if (!m_prev_ms) begin nxt = M_STBY; m_hur = 1'b1; end
                M_STBY: if (menu) nxt = M_MENU;
                M_MENU: begin
                    if (menu) nxt = M_STBY;
                    else if (top == NL) begin
                        if (m_hur) begin nxt = M_HUR; m_hur = 1'b0; m_load = HUR_S; end
                    end else if (top > 0) begin nxt = M_RUN; m_level = top; end
                    else if (cln) begin nxt = M_CLN; m_load = CLN_S; end
                end
                M_RUN: begin
                    if (menu) nxt = M_STBY;
                    else if (top > 0 && top < NL) m_level = top;
                end
                M_HUR: begin
                    if (menu) begin nxt = M_RET; m_load = RET_S; end
                    else if (done) begin nxt = M_RUN; m_level = NL - 1; end
                end
                M_RET: if (done) nxt = M_STBY;
                M_CLN: if (done) begin nxt = M_STBY; m_acc = 0; end
                default: nxt = M_OFF;
            endcase
        end
        m_prev_ms = ms;
        if (nxt != m_st) m_age = 0; else m_age++;
        m_st = nxt;
    endtask

    function automatic int exp_mode();
        case (m_st)
            M_OFF:         return 15;
            M_STBY, M_MENU: return 0;
            M_RUN:         return m_level;
            M_HUR:         return NL;
            M_RET:         return NL - 1;
            default:       return NL + 1;
        endcase
    endfunction

    function automatic int exp_disp();
        case (m_st)
            M_OFF:              return 3;
            M_STBY, M_MENU:     return 0;
            M_CLN:              return 2;
            default:            return 1;
        endcase
    endfunction

    function automatic int exp_remain();
        if (m_st == M_HUR || m_st == M_RET || m_st == M_CLN) return m_load - m_age / CLK_HZ;
        return 0;
    endfunction

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            model_step(bus_if.machine_state, bus_if.menu_btn, bus_if.level_btn, bus_if.clean_btn);
        end
        #1;
        if (m_valid) begin
            chk("model mode_state", 32'(bus_if.mode_state), 32'(exp_mode()));
            chk("model menu_btn_state", 32'(bus_if.menu_btn_state), 32'(m_st == M_MENU));
            chk("model hurricane_en", 32'(bus_if.hurricane_mode_enabled), 32'(m_hur));
            chk("model remain_s", 32'(bus_if.remain_s), 32'(exp_remain()));
            chk("model disp_sel", 32'(bus_if.disp_sel), 32'(exp_disp()));
            chk("model led", 32'(bus_if.led), (m_st == M_OFF) ? 32'd0 : (32'd1 << exp_mode()));
            chk("model clean_remind", 32'(bus_if.clean_remind), 32'(REM_EN && (m_acc >= REM_S)));
        end
    end

    task automatic press(input bit menu, input logic [NL-1:0] lvl, input bit cln);
        bus_if.menu_btn  = menu;
        bus_if.level_btn = lvl;
        bus_if.clean_btn = cln;
        @(negedge clk);
        bus_if.menu_btn  = 1'b0;
        bus_if.level_btn = '0;
        bus_if.clean_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit quiet;
        rst = 1'b1;
        bus_if.machine_state = 1'b0;
        bus_if.menu_btn      = 1'b0;
        bus_if.level_btn     = '0;
        bus_if.clean_btn     = 1'b0;
        idle(3);
        chk("rst mode_state", 32'(bus_if.mode_state), 32'd15);
        chk("rst disp_sel", 32'(bus_if.disp_sel), 32'd3);
        chk("rst led", 32'(bus_if.led), 32'd0);
        chk("rst hurricane_en", 32'(bus_if.hurricane_mode_enabled), 32'd0);
        chk("rst clean_remind", 32'(bus_if.clean_remind), 32'd0);

        rst = 1'b0;
        bus_if.machine_state = 1'b1;
        idle(1);
        chk("power-on mode_state", 32'(bus_if.mode_state), 32'd0);
        chk("power-on disp_sel", 32'(bus_if.disp_sel), 32'd0);
        chk("power-on hurricane_en", 32'(bus_if.hurricane_mode_enabled), 32'd1);
        chk("power-on led", 32'(bus_if.led), 32'd1);

        press(1'b1, 3'b000, 1'b0);
        chk("menu armed", 32'(bus_if.menu_btn_state), 32'd1);
        press(1'b0, 3'b100, 1'b0);
        chk("hurricane mode_state", 32'(bus_if.mode_state), 32'd3);
        chk("hurricane remain_s", 32'(bus_if.remain_s), 32'd3);
        chk("hurricane used", 32'(bus_if.hurricane_mode_enabled), 32'd0);
        idle(29);
        chk("hurricane last second", 32'(bus_if.remain_s), 32'd1);
        idle(1);
        chk("hurricane expiry mode", 32'(bus_if.mode_state), 32'd2);
        chk("hurricane expiry remain", 32'(bus_if.remain_s), 32'd0);
        press(1'b1, 3'b000, 1'b0);
        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b100, 1'b0);
        chk("second hurricane ignored", 32'(bus_if.mode_state), 32'd0);
        chk("still in menu", 32'(bus_if.menu_btn_state), 32'd1);

        press(1'b1, 3'b000, 1'b0);
        bus_if.machine_state = 1'b0;
        idle(1);
        chk("power-off mode", 32'(bus_if.mode_state), 32'd15);
        bus_if.machine_state = 1'b1;
        idle(1);
        chk("re-power hurricane_en", 32'(bus_if.hurricane_mode_enabled), 32'd1);
        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b100, 1'b0);
        press(1'b1, 3'b000, 1'b0);
        chk("return mode_state", 32'(bus_if.mode_state), 32'd2);
        chk("return remain_s", 32'(bus_if.remain_s), 32'd2);
        idle(19);
        chk("return last second", 32'(bus_if.remain_s), 32'd1);
        idle(1);
        chk("return expiry", 32'(bus_if.mode_state), 32'd0);

        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b000, 1'b1);
        chk("clean mode_state", 32'(bus_if.mode_state), 32'd4);
        chk("clean disp_sel", 32'(bus_if.disp_sel), 32'd2);
        chk("clean led", 32'(bus_if.led), 32'd16);
        chk("clean remain 4", 32'(bus_if.remain_s), 32'd4);
        for (int k = 1; k <= 3; k++) begin
            idle(10);
            chk("clean countdown", 32'(bus_if.remain_s), 32'(4 - k));
        end
        idle(10);
        chk("clean expiry", 32'(bus_if.mode_state), 32'd0);

        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b000, 1'b1);
        idle(15);
        bus_if.machine_state = 1'b0;
        idle(1);
        chk("drop mid-clean mode", 32'(bus_if.mode_state), 32'd15);
        chk("drop mid-clean led", 32'(bus_if.led), 32'd0);
        chk("drop mid-clean remain", 32'(bus_if.remain_s), 32'd0);
        bus_if.machine_state = 1'b1;
        idle(1);
        press(1'b1, 3'b000, 1'b0);
        press(1'b1, 3'b001, 1'b0);
        chk("menu beats level", 32'(bus_if.menu_btn_state), 32'd0);
        chk("menu beats level mode", 32'(bus_if.mode_state), 32'd0);
        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b011, 1'b0);
        chk("highest level wins", 32'(bus_if.mode_state), 32'd2);
        press(1'b0, 3'b001, 1'b1);
        chk("run level change", 32'(bus_if.mode_state), 32'd1);
        press(1'b1, 3'b000, 1'b0);

        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b000, 1'b1);
        idle(40);
        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b001, 1'b0);
        idle(49);
        chk("remind before 5 s", 32'(bus_if.clean_remind), 32'd0);
        idle(1);
        chk("remind after 5 s", 32'(bus_if.clean_remind), 32'(REM_EN));
        press(1'b1, 3'b000, 1'b0);
        press(1'b1, 3'b000, 1'b0);
        press(1'b0, 3'b000, 1'b1);
        idle(40);
        chk("remind cleared by clean", 32'(bus_if.clean_remind), 32'd0);
        chk("standby after clean", 32'(bus_if.mode_state), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            quiet = ((i / 150) % 2) == 1;
            rst                  = ($urandom_range(0, 999) == 0);
            bus_if.machine_state = ($urandom_range(0, 99) != 0);
            bus_if.menu_btn      = ($urandom_range(0, quiet ? 60 : 6) == 0);
            bus_if.level_btn     = ($urandom_range(0, quiet ? 40 : 5) == 0) ?
                                   3'($urandom_range(1, 7)) : 3'b000;
            bus_if.clean_btn     = ($urandom_range(0, quiet ? 40 : 4) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/range_hood_mode_ctrl.md
RANGE_HOOD_MODE_CTRL -- requirements
Module: range_hood_mode_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_LEVELS, 3: fan levels; top level is hurricane.
- CLK_HZ, 100000000: clk cycles per second tick.
- HURRICANE_S, 60: hurricane duration, s.
- RETURN_S, 60: delayed-return duration, s.
- CLEAN_S, 180: self-clean duration, s.
- REMIND_S, 36000: run-time threshold for clean reminder, s.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- machine_state  in  1  power level from on/off control
- menu_btn  in  1  one-cycle pulse
- level_btn  in  NUM_LEVELS  one-cycle pulses; bit i selects level i+1
- clean_btn  in  1  one-cycle pulse
- mode_state  out  4  0 standby, 1..NUM_LEVELS fan level, NUM_LEVELS+1 self-clean, 15 off
- menu_btn_state  out  1  menu armed
- hurricane_mode_enabled  out  1  hurricane still available this power cycle
- remain_s  out  16  seconds left in the current timed state, else 0
- disp_sel  out  2  0 time, 1 smoker, 2 self-clean, 3 blank
- led  out  NUM_LEVELS+2  one-hot mode indicator
- clean_remind  out  1  run-time reminder

Function
REQ-003 The FSM SHALL have states OFF, STANDBY, MENU, RUN, HURRICANE, RETURN and CLEAN; all outputs SHALL be registered.
REQ-004 machine_state low SHALL force OFF on the next clock from any state, clearing menu_btn_state and remain_s; OFF SHALL output mode_state=15, disp_sel=3 and led=0.
REQ-005 A machine_state rising edge SHALL enter STANDBY and set hurricane_mode_enabled=1.
REQ-006 menu_btn in STANDBY SHALL enter MENU with menu_btn_state=1; a second menu_btn in MENU SHALL return to STANDBY.
REQ-007 In MENU, level_btn bit i < NUM_LEVELS-1 SHALL enter RUN at level i+1.
REQ-008 In MENU, the top bit SHALL enter HURRICANE only if hurricane_mode_enabled=1; otherwise the press SHALL be ignored.
REQ-009 Entering HURRICANE SHALL clear hurricane_mode_enabled and load remain_s=HURRICANE_S.
REQ-010 On expiry of HURRICANE, the block SHALL enter RUN at level NUM_LEVELS-1.
REQ-011 In MENU, clean_btn SHALL enter CLEAN with remain_s=CLEAN_S and disp_sel=2; clean_btn outside MENU SHALL be ignored.
REQ-012 In RUN, level_btn bits except the top bit SHALL change level directly.
REQ-013 In RUN, menu_btn SHALL return to STANDBY immediately.
REQ-014 In HURRICANE, menu_btn SHALL enter RETURN with remain_s=RETURN_S and the fan held at level NUM_LEVELS-1.
REQ-015 Expiry of RETURN SHALL enter STANDBY; level_btn in RETURN SHALL be ignored.
REQ-016 Expiry of CLEAN SHALL enter STANDBY.
REQ-017 An internal prescaler SHALL count 0..CLK_HZ-1 and restart on every state change; each wrap SHALL decrement remain_s.
REQ-018 Expiry SHALL occur on the tick where remain_s goes from 1 to 0, with the transition taking effect in that same cycle.
REQ-019 Simultaneous inputs SHALL resolve as follows: menu_btn beats level_btn and clean_btn; the highest set level_btn bit wins; level_btn beats clean_btn.
REQ-020 disp_sel SHALL be 0 in STANDBY/MENU, 1 in RUN/HURRICANE/RETURN, 2 in CLEAN and 3 in OFF; led bit = mode_state index; remain_s SHALL be 0 in untimed states.

Reset
REQ-021 rst SHALL force OFF with mode_state=15, menu_btn_state=0, hurricane_mode_enabled=0, remain_s=0, disp_sel=3, led=0, clean_remind=0, prescaler=0 and run-time accumulator=0.
REQ-022 rst SHALL take priority over all inputs, including machine_state.

Configuration
REQ-023 With CLEAN_REMIND_EN defined:
- A 32-bit saturating accumulator SHALL increment once per second tick in RUN, HURRICANE and RETURN.
- clean_remind SHALL be 1 while accumulator >= REMIND_S.
- Completion of CLEAN SHALL clear the accumulator; OFF SHALL NOT clear it.
REQ-024 Without CLEAN_REMIND_EN, the block SHALL contain no accumulator and clean_remind SHALL be constant 0.

Verification
REQ-025 The bench SHALL use CLK_HZ=10, NUM_LEVELS=3, HURRICANE_S=3, RETURN_S=2, CLEAN_S=4 and REMIND_S=5, and SHALL cover these scenarios:
- rst, then machine_state=1 -> STANDBY, mode_state=0, disp_sel=0, hurricane_mode_enabled=1.
- Press menu, then level_btn=3'b100 -> mode_state=3, remain_s=3; after 30 clks mode_state=2, remain_s=0; repeat menu+3'b100 -> ignored.
- In HURRICANE, press menu -> RETURN, mode_state=2, remain_s=2; 20 clks later mode_state=0.
- menu, then clean_btn -> mode_state=4, disp_sel=2; remain_s counts 4,3,2,1; after 40 clks mode_state=0.
- Drop machine_state mid-CLEAN -> next clk mode_state=15, led=0, remain_s=0; menu_btn and level_btn pressed together in MENU -> menu wins.
- With CLEAN_REMIND_EN, run level 1 for 50 clks -> clean_remind=1; complete CLEAN -> clean_remind=0; without the macro, clean_remind stays 0.
